// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared encodings for the EX hazard controller: FSM states and the forwarding
// select codes also consumed by the EX operand muxes.
package ex_hazard_ctrl_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] MC_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    StRun     = RUN,
    StLuStall = LU_STALL,
    StMcWait  = MC_WAIT
  } hz_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline-side bundle for ex_hazard_ctrl. Optional HAZARD_PERF_EN adds the
// perf_clr input and the stall_cnt / flush_cnt counters.
interface ex_hazard_ctrl_if #(
  parameter int unsigned REG_W = 4
);
  logic [REG_W-1:0] ifid_rn, ifid_rm;
  logic             ifid_uses_rn, ifid_uses_rm;
  logic [REG_W-1:0] idex_rn, idex_rm, idex_rd;
  logic             idex_mem_read, idex_reg_write;
  logic [REG_W-1:0] exmem_rd, memwb_rd;
  logic             exmem_reg_write, memwb_reg_write;
  logic             ex_branch_taken;
  logic             mc_start, mc_done;

  logic             pc_en, ifid_en, idex_en;
  logic             ifid_flush, idex_flush, exmem_bubble;
  logic [1:0]       fwd_sel_rn, fwd_sel_rm;
  logic             busy, mc_timeout;

`ifdef HAZARD_PERF_EN
  logic             perf_clr;
  logic [15:0]      stall_cnt, flush_cnt;

  modport master (
    output ifid_rn, ifid_rm, ifid_uses_rn, ifid_uses_rm, idex_rn, idex_rm, idex_rd,
           idex_mem_read, idex_reg_write, exmem_rd, memwb_rd, exmem_reg_write,
           memwb_reg_write, ex_branch_taken, mc_start, mc_done, perf_clr,
    input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble,
           fwd_sel_rn, fwd_sel_rm, busy, mc_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_rn, ifid_rm, ifid_uses_rn, ifid_uses_rm, idex_rn, idex_rm, idex_rd,
           idex_mem_read, idex_reg_write, exmem_rd, memwb_rd, exmem_reg_write,
           memwb_reg_write, ex_branch_taken, mc_start, mc_done, perf_clr,
    output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble,
           fwd_sel_rn, fwd_sel_rm, busy, mc_timeout, stall_cnt, flush_cnt
  );
`else
  modport master (
    output ifid_rn, ifid_rm, ifid_uses_rn, ifid_uses_rm, idex_rn, idex_rm, idex_rd,
           idex_mem_read, idex_reg_write, exmem_rd, memwb_rd, exmem_reg_write,
           memwb_reg_write, ex_branch_taken, mc_start, mc_done,
    input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble,
           fwd_sel_rn, fwd_sel_rm, busy, mc_timeout
  );

  modport slave (
    input  ifid_rn, ifid_rm, ifid_uses_rn, ifid_uses_rm, idex_rn, idex_rm, idex_rd,
           idex_mem_read, idex_reg_write, exmem_rd, memwb_rd, exmem_reg_write,
           memwb_reg_write, ex_branch_taken, mc_start, mc_done,
    output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble,
           fwd_sel_rn, fwd_sel_rm, busy, mc_timeout
  );
`endif

endinterface

// File: rtl/ex_hazard_ctrl_fwd_select.sv
// Operand source select for one EX source register; the younger EX/MEM result
// wins over MEM/WB. Register 0 is matched like any other.
module ex_hazard_ctrl_fwd_select
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 4
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             exmem_reg_write,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic             memwb_reg_write,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (exmem_reg_write && (exmem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencing: stage enables/flushes, load-use bubbles, branch flush,
// multi-cycle freeze with timeout, operand forwarding. Option: HAZARD_PERF_EN.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W      = 4,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned MC_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  ex_hazard_ctrl_if.slave   hz
);

  localparam logic [2:0] LuInit  = 3'(LOAD_LAT - 1);
  localparam logic [7:0] McLimit = 8'(MC_TIMEOUT);

  hz_state_e  state_q;
  logic [2:0] lu_cnt_q;
  logic [7:0] mc_cnt_q;
  logic       mc_timeout_q;

  logic       load_use, mc_release;
  logic       pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble;
  logic [1:0] sel_rn, sel_rm;

  assign load_use = hz.idex_mem_read && hz.idex_reg_write &&
                    ((hz.ifid_uses_rn && (hz.ifid_rn == hz.idex_rd)) ||
                     (hz.ifid_uses_rm && (hz.ifid_rm == hz.idex_rd)));

  assign mc_release = hz.mc_done || (mc_cnt_q == McLimit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      lu_cnt_q     <= '0;
      mc_cnt_q     <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          // Branch outranks everything, including an illegal simultaneous mc_start.
          if (hz.ex_branch_taken) begin
            state_q <= StRun;
          end else if (hz.mc_start) begin
            mc_cnt_q <= '0;
            state_q  <= StMcWait;
          end else if (load_use && (LOAD_LAT > 1)) begin
            lu_cnt_q <= LuInit;
            state_q  <= StLuStall;
          end
        end
        StLuStall: begin
          lu_cnt_q <= lu_cnt_q - 3'd1;
          if (lu_cnt_q <= 3'd1) begin
            state_q <= StRun;
          end
        end
        StMcWait: begin
          if (hz.mc_done) begin
            state_q <= StRun;
          end else if (mc_cnt_q == McLimit) begin
            mc_timeout_q <= 1'b1;
            state_q      <= StRun;
          end else begin
            mc_cnt_q <= mc_cnt_q + 8'd1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    if (!reset) begin
      case (state_q)
        StRun: begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          idex_en = 1'b1;
          if (hz.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (hz.mc_start) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        StLuStall: begin
          idex_en    = 1'b1;
          idex_flush = 1'b1;
        end
        StMcWait: begin
          if (mc_release) begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            idex_en = 1'b1;
          end else begin
            exmem_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  ex_hazard_ctrl_fwd_select #(.REG_W(REG_W)) u_fwd_rn (
    .src             (hz.idex_rn),
    .exmem_rd        (hz.exmem_rd),
    .exmem_reg_write (hz.exmem_reg_write),
    .memwb_rd        (hz.memwb_rd),
    .memwb_reg_write (hz.memwb_reg_write),
    .sel             (sel_rn)
  );

  ex_hazard_ctrl_fwd_select #(.REG_W(REG_W)) u_fwd_rm (
    .src             (hz.idex_rm),
    .exmem_rd        (hz.exmem_rd),
    .exmem_reg_write (hz.exmem_reg_write),
    .memwb_rd        (hz.memwb_rd),
    .memwb_reg_write (hz.memwb_reg_write),
    .sel             (sel_rm)
  );

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.idex_en      = idex_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_bubble = exmem_bubble;
  assign hz.fwd_sel_rn   = reset ? FWD_RF : sel_rn;
  assign hz.fwd_sel_rm   = reset ? FWD_RF : sel_rm;
  assign hz.busy         = (state_q != StRun);
  assign hz.mc_timeout   = mc_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        flush_evt;

  assign flush_evt = (state_q == StRun) && hz.ex_branch_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (hz.perf_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && (stall_cnt_q != 16'hffff)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush_evt && (flush_cnt_q != 16'hffff)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule
